// File: rtl/gpr_sched_pkg.sv
// Shared types and width helpers for the GPR operand-fetch sequencer.
// The operand bundle is sized for the default configuration.
package gpr_sched_pkg;

    localparam int unsigned LANE_W          = 32;
    localparam int unsigned DEF_NUM_THREADS = 4;
    localparam int unsigned DEF_NUM_WARPS   = 4;
    localparam int unsigned DEF_NUM_REGS    = 64;
    localparam int unsigned DEF_TAG_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD12,
        RD3,
        RSP
    } state_e;

    function automatic int unsigned f_raddr_w(input int unsigned nw, input int unsigned nr);
        return $clog2(nw * nr);
    endfunction

    function automatic int unsigned f_wid_w(input int unsigned nw);
        return $clog2(nw);
    endfunction

    function automatic int unsigned f_rid_w(input int unsigned nr);
        return $clog2(nr);
    endfunction

    localparam int unsigned DEF_WID_W = f_wid_w(DEF_NUM_WARPS);

    typedef logic [DEF_NUM_THREADS-1:0][LANE_W-1:0] lanes_t;

    typedef struct packed {
        logic [DEF_WID_W-1:0] wid;
        logic [DEF_TAG_W-1:0] tag;
        lanes_t               rs1;
        lanes_t               rs2;
        lanes_t               rs3;
    } gpr_operands_t;

endpackage

// File: rtl/gpr_bypass_mux.sv
// Per-lane writeback bypass for one GPR read port: substitutes in-flight
// writeback data for lanes whose write targets the address being read.
module gpr_bypass_mux
    import gpr_sched_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned RADDR_W     = 8
) (
    input  logic [RADDR_W-1:0]                 i_raddr,
    input  logic [NUM_THREADS-1:0][LANE_W-1:0] i_rdata,
    input  logic                               i_wb_en,
    input  logic [RADDR_W-1:0]                 i_wb_addr,
    input  logic [NUM_THREADS-1:0]             i_wb_tmask,
    input  logic [NUM_THREADS-1:0][LANE_W-1:0] i_wb_data,
    output logic [NUM_THREADS-1:0][LANE_W-1:0] o_data
);

    logic w_hit;

    assign w_hit = i_wb_en && (i_wb_addr == i_raddr);

    always_comb begin
        o_data = i_rdata;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            if (w_hit && i_wb_tmask[i]) begin
                o_data[i] = i_wb_data[i];
            end
        end
    end

endmodule

// File: rtl/gpr_read_sched.sv
// Operand-fetch sequencer: reads rs1/rs2 in one cycle and rs3 in a second,
// then holds the operands under a valid/ready handshake. Option: GPR_WB_BYPASS_EN.
module gpr_read_sched
    import gpr_sched_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_REGS    = 64,
    parameter int unsigned TAG_W       = 8,
    localparam int unsigned RADDR_W    = f_raddr_w(NUM_WARPS, NUM_REGS),
    localparam int unsigned WID_W      = f_wid_w(NUM_WARPS),
    localparam int unsigned RID_W      = f_rid_w(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WID_W-1:0]                   in_wid,
    input  logic [RID_W-1:0]                   in_rs1,
    input  logic [RID_W-1:0]                   in_rs2,
    input  logic [RID_W-1:0]                   in_rs3,
    input  logic                               in_use_rs3,
    input  logic [TAG_W-1:0]                   in_tag,
    output logic [RADDR_W-1:0]                 raddr1,
    output logic [RADDR_W-1:0]                 raddr2,
    input  logic [NUM_THREADS-1:0][LANE_W-1:0] rdata1,
    input  logic [NUM_THREADS-1:0][LANE_W-1:0] rdata2,
    input  logic                               wb_valid,
    input  logic [WID_W-1:0]                   wb_wid,
    input  logic [RID_W-1:0]                   wb_rd,
    input  logic [NUM_THREADS-1:0]             wb_tmask,
    input  logic [NUM_THREADS-1:0][LANE_W-1:0] wb_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_THREADS-1:0][LANE_W-1:0] out_rs1_data,
    output logic [NUM_THREADS-1:0][LANE_W-1:0] out_rs2_data,
    output logic [NUM_THREADS-1:0][LANE_W-1:0] out_rs3_data,
    output logic [WID_W-1:0]                   out_wid,
    output logic [TAG_W-1:0]                   out_tag
);

    state_e r_state;
    state_e w_state_nxt;

    logic [WID_W-1:0] r_wid;
    logic [RID_W-1:0] r_rs1;
    logic [RID_W-1:0] r_rs2;
    logic [RID_W-1:0] r_rs3;
    logic             r_use_rs3;
    logic [TAG_W-1:0] r_tag;

    logic [NUM_THREADS-1:0][LANE_W-1:0] r_d1;
    logic [NUM_THREADS-1:0][LANE_W-1:0] r_d2;
    logic [NUM_THREADS-1:0][LANE_W-1:0] r_d3;

    logic                               w_in_ready;
    logic                               w_accept;
    logic [RID_W-1:0]                   w_rid1;
    logic [RADDR_W-1:0]                 w_raddr1;
    logic [RADDR_W-1:0]                 w_raddr2;
    logic [NUM_THREADS-1:0][LANE_W-1:0] w_port1;
    logic [NUM_THREADS-1:0][LANE_W-1:0] w_port2;
    logic [NUM_THREADS-1:0][LANE_W-1:0] w_cap1;
    logic [NUM_THREADS-1:0][LANE_W-1:0] w_cap2;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RD12;
                end
            end
            RD12: w_state_nxt = r_use_rs3 ? RD3 : RSP;
            RD3:  w_state_nxt = RSP;
            RSP: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? RD12 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (reset) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rs2 stays on port 2 during RD3 so the address bus does not toggle needlessly.
    always_comb begin
        w_raddr1 = '0;
        w_raddr2 = '0;
        w_rid1   = r_rs1;
        unique case (r_state)
            RD12: begin
                w_raddr1 = {r_wid, r_rs1};
                w_raddr2 = {r_wid, r_rs2};
            end
            RD3: begin
                w_raddr1 = {r_wid, r_rs3};
                w_raddr2 = {r_wid, r_rs2};
                w_rid1   = r_rs3;
            end
            default: ;
        endcase
    end

`ifdef GPR_WB_BYPASS_EN
    logic [RADDR_W-1:0] w_wb_addr;
    logic               w_wb_en;

    assign w_wb_addr = {wb_wid, wb_rd};
    assign w_wb_en   = wb_valid && (wb_rd != '0);

    gpr_bypass_mux #(
        .NUM_THREADS (NUM_THREADS),
        .RADDR_W     (RADDR_W)
    ) u_bypass1 (
        .i_raddr    (w_raddr1),
        .i_rdata    (rdata1),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (w_wb_addr),
        .i_wb_tmask (wb_tmask),
        .i_wb_data  (wb_data),
        .o_data     (w_port1)
    );

    gpr_bypass_mux #(
        .NUM_THREADS (NUM_THREADS),
        .RADDR_W     (RADDR_W)
    ) u_bypass2 (
        .i_raddr    (w_raddr2),
        .i_rdata    (rdata2),
        .i_wb_en    (w_wb_en),
        .i_wb_addr  (w_wb_addr),
        .i_wb_tmask (wb_tmask),
        .i_wb_data  (wb_data),
        .o_data     (w_port2)
    );
`else
    logic w_unused_wb;

    assign w_port1     = rdata1;
    assign w_port2     = rdata2;
    assign w_unused_wb = ^{wb_valid, wb_wid, wb_rd, wb_tmask, wb_data};
`endif

    // r0 is hardwired zero whatever the RAM or the bypass returns.
    assign w_cap1 = (w_rid1 == '0) ? '0 : w_port1;
    assign w_cap2 = (r_rs2 == '0) ? '0 : w_port2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wid     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs3     <= '0;
            r_use_rs3 <= 1'b0;
            r_tag     <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
        end else begin
            if (w_accept) begin
                r_wid     <= in_wid;
                r_rs1     <= in_rs1;
                r_rs2     <= in_rs2;
                r_rs3     <= in_rs3;
                r_use_rs3 <= in_use_rs3;
                r_tag     <= in_tag;
            end
            if (r_state == RD12) begin
                r_d1 <= w_cap1;
                r_d2 <= w_cap2;
                r_d3 <= '0;
            end
            if (r_state == RD3) begin
                r_d3 <= w_cap1;
            end
        end
    end

    // Request registers only reload on accept, which also ends RSP, so they
    // double as the stable out_wid/out_tag.
    assign in_ready     = w_in_ready;
    assign raddr1       = w_raddr1;
    assign raddr2       = w_raddr2;
    assign out_valid    = (r_state == RSP);
    assign out_rs1_data = r_d1;
    assign out_rs2_data = r_d2;
    assign out_rs3_data = r_d3;
    assign out_wid      = r_wid;
    assign out_tag      = r_tag;

endmodule

// File: tb/tb_gpr_read_sched.sv
// Scoreboard bench for gpr_read_sched: directed requests push expected
// operand bundles; a negedge monitor pops and compares on each output transfer.
module tb_gpr_read_sched;
    import gpr_sched_pkg::*;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_wid;
    logic [5:0]          in_rs1;
    logic [5:0]          in_rs2;
    logic [5:0]          in_rs3;
    logic                in_use_rs3;
    logic [7:0]          in_tag;
    logic [7:0]          raddr1;
    logic [7:0]          raddr2;
    lanes_t              rdata1;
    lanes_t              rdata2;
    logic                wb_valid;
    logic [1:0]          wb_wid;
    logic [5:0]          wb_rd;
    logic [3:0]          wb_tmask;
    lanes_t              wb_data;
    logic                out_valid;
    logic                out_ready;
    lanes_t              out_rs1_data;
    lanes_t              out_rs2_data;
    lanes_t              out_rs3_data;
    logic [1:0]          out_wid;
    logic [7:0]          out_tag;

    lanes_t              mem [256];
    gpr_operands_t       exp_q [$];
    int                  total = 0;
    int                  bad   = 0;

    gpr_read_sched #(
        .NUM_THREADS (4),
        .NUM_WARPS   (4),
        .NUM_REGS    (64),
        .TAG_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wid       (in_wid),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs3       (in_rs3),
        .in_use_rs3   (in_use_rs3),
        .in_tag       (in_tag),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .wb_valid     (wb_valid),
        .wb_wid       (wb_wid),
        .wb_rd        (wb_rd),
        .wb_tmask     (wb_tmask),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rs3_data (out_rs3_data),
        .out_wid      (out_wid),
        .out_tag      (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous RAM model.
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic gpr_operands_t mk(input logic [1:0] wid, input logic [7:0] tag,
                                         input logic [31:0] v1, input logic [31:0] v2,
                                         input logic [31:0] v3);
        gpr_operands_t e;
        e.wid = wid;
        e.tag = tag;
        e.rs1 = {4{v1}};
        e.rs2 = {4{v2}};
        e.rs3 = {4{v3}};
        return e;
    endfunction

    // Returns one cycle after the accept edge (DUT in RD12).
    task automatic issue(input logic [1:0] wid, input logic [5:0] r1, input logic [5:0] r2,
                         input logic [5:0] r3, input logic u3, input logic [7:0] tag,
                         input logic push, input gpr_operands_t e);
        int n;
        in_valid   = 1'b1;
        in_wid     = wid;
        in_rs1     = r1;
        in_rs2     = r2;
        in_rs3     = r3;
        in_use_rs3 = u3;
        in_tag     = tag;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", {127'd0, in_ready}, 128'd1);
        if (push) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got tag %h expected no output", out_tag);
            end else begin
                gpr_operands_t e;
                e = exp_q.pop_front();
                chk("out_rs1", out_rs1_data, e.rs1);
                chk("out_rs2", out_rs2_data, e.rs2);
                chk("out_rs3", out_rs3_data, e.rs3);
                chk("out_wid", {126'd0, out_wid}, {126'd0, e.wid});
                chk("out_tag", {120'd0, out_tag}, {120'd0, e.tag});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gpr_operands_t e;
        lanes_t        bl;

        for (int a = 0; a < 256; a++) mem[a] = {4{32'h1000_0000 | 32'(a)}};
        mem[{2'd1, 6'd5}]  = {4{32'h11}};
        mem[{2'd1, 6'd6}]  = {4{32'h22}};
        mem[{2'd1, 6'd40}] = {4{32'hDEADBEEF}};
        mem[{2'd3, 6'd0}]  = {4{32'hFFFFFFFF}};
        mem[{2'd3, 6'd6}]  = {4{32'h33}};
        mem[{2'd0, 6'd1}]  = {4{32'hA1}};
        mem[{2'd0, 6'd2}]  = {4{32'hA2}};
        mem[{2'd0, 6'd3}]  = {4{32'hB3}};
        mem[{2'd0, 6'd4}]  = {4{32'hB4}};
        mem[{2'd2, 6'd7}]  = {4{32'h55}};

        reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
        in_use_rs3 = 1'b0; in_tag = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_tmask = '0; wb_data = '0;
        tick();
        tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_raddr1", {120'd0, raddr1}, 128'd0);
        chk("rst_raddr2", {120'd0, raddr2}, 128'd0);
        chk("rst_out_tag", {120'd0, out_tag}, 128'd0);
        chk("rst_out_rs1", out_rs1_data, 128'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", {127'd0, in_ready}, 128'd1);

        // Basic two-source read: 2-cycle latency.
        issue(2'd1, 6'd5, 6'd6, 6'd0, 1'b0, 8'h3C, 1'b1, mk(2'd1, 8'h3C, 32'h11, 32'h22, 32'h0));
        chk("basic_rd12_valid", {127'd0, out_valid}, 128'd0);
        chk("basic_rd12_raddr1", {120'd0, raddr1}, {120'd0, 2'd1, 6'd5});
        chk("basic_rd12_raddr2", {120'd0, raddr2}, {120'd0, 2'd1, 6'd6});
        tick();
        chk("basic_e2_valid", {127'd0, out_valid}, 128'd1);
        chk("basic_rsp_raddr1", {120'd0, raddr1}, 128'd0);
        tick();
        chk("basic_drained", {127'd0, out_valid}, 128'd0);

        // Three-source read: 3-cycle latency, rs3 on port 1 during RD3.
        issue(2'd1, 6'd5, 6'd6, 6'd40, 1'b1, 8'h4D, 1'b1,
              mk(2'd1, 8'h4D, 32'h11, 32'h22, 32'hDEADBEEF));
        tick();
        chk("rs3_rd3_raddr1", {120'd0, raddr1}, {120'd0, 2'd1, 6'd40});
        chk("rs3_rd3_raddr2", {120'd0, raddr2}, {120'd0, 2'd1, 6'd6});
        chk("rs3_e2_valid", {127'd0, out_valid}, 128'd0);
        tick();
        chk("rs3_e3_valid", {127'd0, out_valid}, 128'd1);
        tick();

        // Register zero is forced to zero despite RAM contents.
        issue(2'd3, 6'd0, 6'd6, 6'd0, 1'b0, 8'h01, 1'b1, mk(2'd3, 8'h01, 32'h0, 32'h33, 32'h0));
        tick();
        tick();

        // Backpressure with a second request queued behind.
        out_ready = 1'b0;
        issue(2'd0, 6'd1, 6'd2, 6'd0, 1'b0, 8'h51, 1'b1, mk(2'd0, 8'h51, 32'hA1, 32'hA2, 32'h0));
        in_valid = 1'b1; in_wid = 2'd0; in_rs1 = 6'd3; in_rs2 = 6'd4; in_rs3 = 6'd0;
        in_use_rs3 = 1'b0; in_tag = 8'h52;
        exp_q.push_back(mk(2'd0, 8'h52, 32'hB3, 32'hB4, 32'h0));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_rs1", out_rs1_data, {4{32'hA1}});
            chk("stall_tag", {120'd0, out_tag}, {120'd0, 8'h51});
            chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_rd12_valid", {127'd0, out_valid}, 128'd0);
        chk("b2b_rd12_raddr1", {120'd0, raddr1}, {120'd0, 2'd0, 6'd3});
        tick();
        chk("b2b_second_valid", {127'd0, out_valid}, 128'd1);
        tick();
        chk("b2b_drained", {127'd0, out_valid}, 128'd0);

        // Writeback coincident with RD12 of a read of {2,7} on both ports.
`ifdef GPR_WB_BYPASS_EN
        bl = {32'h55, 32'hAA, 32'h55, 32'hAA};
`else
        bl = {4{32'h55}};
`endif
        e = mk(2'd2, 8'h77, 32'h0, 32'h0, 32'h0);
        e.rs1 = bl;
        e.rs2 = bl;
        issue(2'd2, 6'd7, 6'd7, 6'd0, 1'b0, 8'h77, 1'b1, e);
        wb_valid = 1'b1; wb_wid = 2'd2; wb_rd = 6'd7; wb_tmask = 4'b0101; wb_data = {4{32'hAA}};
        tick();
        wb_valid = 1'b0; wb_tmask = '0; wb_data = '0;
        chk("byp_valid", {127'd0, out_valid}, 128'd1);
        tick();

        // Reset during RD3 discards the request.
        issue(2'd1, 6'd5, 6'd6, 6'd40, 1'b1, 8'h99, 1'b0, e);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_valid", {127'd0, out_valid}, 128'd0);
        end
        issue(2'd1, 6'd40, 6'd5, 6'd6, 1'b1, 8'hA5, 1'b1,
              mk(2'd1, 8'hA5, 32'hDEADBEEF, 32'h11, 32'h22));
        tick();
        tick();
        chk("postrst_req_valid", {127'd0, out_valid}, 128'd1);
        tick();
        tick();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_read_sched.md
# gpr_read_sched

Operand-fetch sequencer between the issue stage and the per-warp GPR RAMs. It accepts one register-read request per handshake and drives the two asynchronous RAM read ports. When a third source is needed, rs3 is fetched in a second read cycle, so the RAMs keep only two read ports. The captured rs1/rs2/rs3 lane data is presented downstream with a valid/ready handshake.

## Interface
Parameters:
- NUM_THREADS, default 4: lanes per warp; each lane datum is 32 bits.
- NUM_WARPS, default 4: warps sharing the RAMs.
- NUM_REGS, default 64: registers per warp (32 int + 32 fp).
- TAG_W, default 8: opaque request tag width.

Ports (RADDR_W = clog2(NUM_WARPS·NUM_REGS), WID_W = clog2(NUM_WARPS), RID_W = clog2(NUM_REGS)):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_wid  in  WID_W  warp id.
- in_rs1 / in_rs2 / in_rs3  in  RID_W each  source register ids.
- in_use_rs3  in  1  fetch rs3; when 0, rs3 data is zero.
- in_tag  in  TAG_W  passed through unchanged.
- raddr1 / raddr2  out  RADDR_W each  RAM read addresses, {wid, rid}.
- rdata1 / rdata2  in  NUM_THREADS×32 each  RAM read data, combinational on raddr.
- wb_valid, wb_wid, wb_rd, wb_tmask (NUM_THREADS), wb_data (NUM_THREADS×32)  in  writeback snoop.
- out_valid  out  1  operands valid.
- out_ready  in  1  consumer accepts.
- out_rs1_data / out_rs2_data / out_rs3_data  out  NUM_THREADS×32 each  operand lanes.
- out_wid  out  WID_W  warp id of the operands.
- out_tag  out  TAG_W  tag of the operands.

## Operation
- FSM states: IDLE, RD12, RD3, RSP. Reset → IDLE.
- IDLE:
  - in_ready = 1.
  - On accept, latch wid, rs1..3, use_rs3 and tag, then go to RD12.
- RD12:
  - raddr1 = {wid, rs1}, raddr2 = {wid, rs2}.
  - At the clock edge, capture rdata1/rdata2 into the rs1/rs2 registers.
  - Next state is RD3 if use_rs3, otherwise RSP (rs3 register cleared to 0).
- RD3:
  - raddr1 = {wid, rs3}; raddr2 holds {wid, rs2} with its data ignored.
  - Capture rdata1 into the rs3 register, then go to RSP.
- RSP:
  - out_valid = 1; output registers stay stable until out_valid & out_ready.
  - in_ready = out_ready, which allows back-to-back operation.
  - On out_ready with a new accept, go to RD12 with the new request; on out_ready alone, go to IDLE.
- Register 0 reads return all-zero lanes, forced regardless of rdata.
- Captured operands are not updated by later writebacks; the scoreboard guarantees no RAW hazard after capture.
- Outside RD12/RD3, raddr1/raddr2 = 0.
- Reset values: state IDLE; out_valid 0; all out_* data, out_wid and out_tag 0; raddr1/raddr2 0. in_ready is 0 while reset is high.
- Reset mid-operation: the in-flight request is discarded with no output, and nothing is presented after reset deasserts.

## Timing
- Accept at edge E0; RD12 occupies the cycle after E0.
- Without rs3: out_valid is high from E2, so latency is 2 cycles.
- With rs3: out_valid is high from E3, so latency is 3 cycles.
- Throughput with out_ready tied high: 1 request per 2 cycles without rs3, 1 per 3 cycles with rs3.
- in_ready never depends on in_valid.
- out_valid never depends on out_ready, and does not drop once raised until accepted.
- The wb_* ports are used only in RD12/RD3, and only by the bypass described under Configuration.

## Configuration
- GPR_WB_BYPASS_EN defined:
  - In RD12/RD3, per lane and per read port, the captured value is wb_data[i] instead of rdata when all of these hold: wb_valid, wb_tmask[i], wb_rd ≠ 0, and {wb_wid, wb_rd} equals that port's read address.
  - This covers same-cycle write/read, where the asynchronous RAM returns stale data.
- GPR_WB_BYPASS_EN undefined:
  - rdata is captured raw.
  - The wb_* ports are unused and marked unused.

## Structure
- Shared package gpr_sched_pkg holds:
  - the state enum (IDLE, RD12, RD3, RSP);
  - the RADDR_W, WID_W and RID_W width functions;
  - the operand-bundle struct (wid, tag, three lane arrays).
- One sub-module, gpr_bypass_mux: per-lane address compare plus 2:1 mux, instantiated once per read port. It is only instantiated under GPR_WB_BYPASS_EN.

## Test plan
- Basic read:
  - Stimulus: RAM warp 1 r5 = 0x11 per lane, r6 = 0x22; request wid=1, rs1=5, rs2=6, use_rs3=0, tag=0x3C, out_ready high.
  - Response: out_valid at E2 with rs1 lanes 0x11, rs2 lanes 0x22, rs3 lanes 0, out_tag 0x3C.
- Three-source read:
  - Stimulus: rs3=40 holding 0xDEADBEEF, use_rs3=1.
  - Response: raddr1 = {wid, 40} during RD3; out_valid at E3 with rs3 lanes 0xDEADBEEF.
- Register zero:
  - Stimulus: rs1=0 with the RAM forced to 0xFFFFFFFF at address {wid, 0}.
  - Response: rs1 lanes are 0.
- Backpressure and back-to-back:
  - Stimulus: out_ready low for 5 cycles, then high, with a second request pending.
  - Response: outputs stable throughout the stall; the second request is accepted on the release edge; its out_valid appears 2 cycles later with no bubble beyond RD12.
- Bypass (GPR_WB_BYPASS_EN):
  - Stimulus: writeback wid=2, rd=7, tmask=0b0101, data 0xAA during RD12 of a request reading {2, 7}; the RAM holds 0x55.
  - Response: lanes 0 and 2 = 0xAA, lanes 1 and 3 = 0x55. Without the macro, all lanes = 0x55.
- Reset mid-operation:
  - Stimulus: assert reset during RD3.
  - Response: out_valid stays 0; the next request after reset completes normally with correct data.
